// File: rtl/dmem_block_mover_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_block_mover_if
//  Description : Single-cycle data-memory port shared by the CPU and the mover.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dmem_block_mover_if;
    logic [31:0] data_addr;
    logic        data_wen;
    logic [31:0] data_write;
    logic [31:0] data_read;

    modport master (
        output data_addr,
        output data_wen,
        output data_write,
        input  data_read
    );

    modport slave (
        input  data_addr,
        input  data_wen,
        input  data_write,
        output data_read
    );
endinterface
`default_nettype wire

// File: rtl/dmem_block_mover.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_block_mover
//  Description : Copies or fills a block of words on the data-memory port.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_block_mover #(
    parameter int DEPTH = 1024,
    parameter int LEN_W = 11
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             start,
    input  wire logic             mode,
    input  wire logic [31:0]      src_addr,
    input  wire logic [31:0]      dst_addr,
    input  wire logic [LEN_W-1:0] len,
    input  wire logic [31:0]      fill_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    dmem_block_mover_if.master    mem
);

    localparam logic [1:0]  S_IDLE = 2'd0;
    localparam logic [1:0]  S_RD   = 2'd1;
    localparam logic [1:0]  S_WR   = 2'd2;
    localparam logic [1:0]  S_DONE = 2'd3;

    localparam logic [32:0] c_DEPTH_EXT = 33'(DEPTH);

    logic [1:0]       r_state;
    logic             r_mode;
    logic [31:0]      r_src;
    logic [31:0]      r_dst;
    logic [LEN_W-1:0] r_len;
    logic [31:0]      r_fill;
    logic [LEN_W-1:0] r_idx;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [31:0]      r_data_addr;
    logic             r_data_wen;
    logic [31:0]      r_data_write;

    logic [32:0]      w_len_ext;
    logic             w_range_err;
    logic [31:0]      w_idx_next;
    logic             w_last;

    // Range check in 33 bits so a large base address cannot wrap past DEPTH.
    assign w_len_ext   = {{(33-LEN_W){1'b0}}, len};
    assign w_range_err = (({1'b0, dst_addr} + w_len_ext) > c_DEPTH_EXT) ||
                         (!mode && (({1'b0, src_addr} + w_len_ext) > c_DEPTH_EXT));
    assign w_idx_next  = {{(32-LEN_W){1'b0}}, r_idx} + 32'd1;
    assign w_last      = (r_idx == (r_len - 1'b1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_mode       <= 1'b0;
            r_src        <= '0;
            r_dst        <= '0;
            r_len        <= '0;
            r_fill       <= '0;
            r_idx        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_data_addr  <= '0;
            r_data_wen   <= 1'b0;
            r_data_write <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_busy       <= 1'b0;
                    r_done       <= 1'b0;
                    r_err        <= 1'b0;
                    r_data_addr  <= '0;
                    r_data_wen   <= 1'b0;
                    r_data_write <= '0;
                    if (start) begin
                        r_mode <= mode;
                        r_src  <= src_addr;
                        r_dst  <= dst_addr;
                        r_len  <= len;
                        r_fill <= fill_data;
                        r_idx  <= '0;
                        r_busy <= 1'b1;
                        if (w_range_err || (len == '0)) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_err   <= w_range_err;
                        end else if (mode) begin
                            r_state      <= S_WR;
                            r_data_addr  <= dst_addr;
                            r_data_wen   <= 1'b1;
                            r_data_write <= fill_data;
                        end else begin
                            r_state     <= S_RD;
                            r_data_addr <= src_addr;
                        end
                    end
                end

                S_RD: begin
                    // The write-data register doubles as the copy buffer.
                    r_state      <= S_WR;
                    r_data_write <= mem.data_read;
                    r_data_addr  <= r_dst + {{(32-LEN_W){1'b0}}, r_idx};
                    r_data_wen   <= 1'b1;
                end

                S_WR: begin
                    if (w_last) begin
                        r_state      <= S_DONE;
                        r_done       <= 1'b1;
                        r_err        <= 1'b0;
                        r_data_addr  <= '0;
                        r_data_wen   <= 1'b0;
                        r_data_write <= '0;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                        if (r_mode) begin
                            r_data_addr <= r_dst + w_idx_next;
                        end else begin
                            r_state      <= S_RD;
                            r_data_addr  <= r_src + w_idx_next;
                            r_data_wen   <= 1'b0;
                            r_data_write <= '0;
                        end
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign err            = r_err;
    assign mem.data_addr  = r_data_addr;
    assign mem.data_wen   = r_data_wen;
    assign mem.data_write = r_data_write;

endmodule
`default_nettype wire

// File: tb/tb_dmem_block_mover.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_block_mover
//  Description : Directed self-checking bench for dmem_block_mover.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_block_mover;

    localparam int DEPTH = 1024;
    localparam int LEN_W = 11;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             mode;
    logic [31:0]      src_addr;
    logic [31:0]      dst_addr;
    logic [LEN_W-1:0] len;
    logic [31:0]      fill_data;
    logic             busy;
    logic             done;
    logic             err;

    logic             init_mem;
    logic             bk_we;
    logic [9:0]       bk_addr;
    logic [31:0]      bk_data;
    logic [31:0]      mem [0:DEPTH-1];

    int checks = 0;
    int errors = 0;

    dmem_block_mover_if bus ();

    dmem_block_mover #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len       (len),
        .fill_data (fill_data),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mem       (bus)
    );

    always #5 clk = ~clk;

    // Memory model: combinational read, posedge write, plus a backdoor port.
    assign bus.data_read = mem[bus.data_addr[9:0]];

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'hA000_0000 + 32'(i);
        end else begin
            if (bus.data_wen) mem[bus.data_addr[9:0]] <= bus.data_write;
            if (bk_we) mem[bk_addr] <= bk_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one request and waits for done; glitch>0 re-pulses start in that busy cycle.
    task automatic run(input logic m, input logic [31:0] s, input logic [31:0] d,
                       input logic [LEN_W-1:0] l, input logic [31:0] f, input int glitch,
                       output int lat, output logic err_v, output logic [31:0] wpat,
                       output logic wen_any);
        mode = m; src_addr = s; dst_addr = d; len = l; fill_data = f;
        start = 1'b1;
        tick();
        start   = 1'b0;
        lat     = 1;
        wpat    = '0;
        wen_any = 1'b0;
        while (!done && lat < 200) begin
            wpat    = {wpat[30:0], bus.data_wen};
            wen_any = wen_any | bus.data_wen;
            start   = (lat == glitch);
            tick();
            lat++;
        end
        start = 1'b0;
        err_v = err;
        wen_any = wen_any | bus.data_wen;
    endtask

    int          lat;
    logic        err_v;
    logic [31:0] wpat;
    logic        wen_any;
    logic        seen_done;

    initial begin
        rst = 1'b1; start = 1'b1; mode = 1'b0; src_addr = 32'd0; dst_addr = 32'd512;
        len = 11'd4; fill_data = '0; init_mem = 1'b1; bk_we = 1'b0; bk_addr = '0; bk_data = '0;

        // Reset held with start asserted
        for (int c = 0; c < 3; c++) begin
            tick();
            init_mem = 1'b0;
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_wen",  32'(bus.data_wen), 32'd0);
            check("rst_done", 32'(done), 32'd0);
        end
        check("rst_addr", bus.data_addr, 32'd0);
        rst = 1'b0; start = 1'b0;
        tick();

        // COPY 0 -> 512, len 4
        run(1'b0, 32'd0, 32'd512, 11'd4, 32'd0, 0, lat, err_v, wpat, wen_any);
        check("copy_lat", 32'(lat), 32'd9);
        check("copy_err", 32'(err_v), 32'd0);
        check("copy_wen_pat", wpat, 32'h0000_0055);
        check("copy_m512", mem[512], 32'hA000_0000);
        check("copy_m513", mem[513], 32'hA000_0001);
        check("copy_m514", mem[514], 32'hA000_0002);
        check("copy_m515", mem[515], 32'hA000_0003);
        tick();
        check("copy_idle_busy", 32'(busy), 32'd0);

        // FILL 100..102
        run(1'b1, 32'd0, 32'd100, 11'd3, 32'hDEAD_BEEF, 0, lat, err_v, wpat, wen_any);
        check("fill_lat", 32'(lat), 32'd4);
        check("fill_err", 32'(err_v), 32'd0);
        check("fill_m100", mem[100], 32'hDEAD_BEEF);
        check("fill_m101", mem[101], 32'hDEAD_BEEF);
        check("fill_m102", mem[102], 32'hDEAD_BEEF);
        check("fill_m99",  mem[99],  32'hA000_0063);
        check("fill_m103", mem[103], 32'hA000_0067);
        tick();

        // Range error: 1020 + 8 > 1024
        run(1'b0, 32'd1020, 32'd0, 11'd8, 32'd0, 0, lat, err_v, wpat, wen_any);
        check("rerr_lat", 32'(lat), 32'd1);
        check("rerr_err", 32'(err_v), 32'd1);
        check("rerr_wen", 32'(wen_any), 32'd0);
        check("rerr_m0", mem[0], 32'hA000_0000);
        check("rerr_m7", mem[7], 32'hA000_0007);
        tick();
        check("rerr_err_clr", 32'(err), 32'd0);

        // Zero length
        run(1'b0, 32'd0, 32'd0, 11'd0, 32'd0, 0, lat, err_v, wpat, wen_any);
        check("len0_lat", 32'(lat), 32'd1);
        check("len0_err", 32'(err_v), 32'd0);
        check("len0_wen", 32'(wen_any), 32'd0);
        tick();

        // Overlapping forward copy with an ignored start while busy
        bk_we = 1'b1; bk_addr = 10'd10; bk_data = 32'd5;
        tick();
        bk_we = 1'b0;
        run(1'b0, 32'd10, 32'd11, 11'd3, 32'd0, 3, lat, err_v, wpat, wen_any);
        check("ovl_lat", 32'(lat), 32'd7);
        check("ovl_m11", mem[11], 32'd5);
        check("ovl_m12", mem[12], 32'd5);
        check("ovl_m13", mem[13], 32'd5);
        check("ovl_m14", mem[14], 32'hA000_000E);
        tick();
        check("ovl_no_requeue", 32'(busy), 32'd0);

        // Reset after the second write of an 8-word copy
        mode = 1'b0; src_addr = 32'd0; dst_addr = 32'd600; len = 11'd8; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_done", 32'(done), 32'd0);
        check("mrst_wen",  32'(bus.data_wen), 32'd0);
        check("mrst_addr", bus.data_addr, 32'd0);
        check("mrst_wdata", bus.data_write, 32'd0);
        seen_done = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            seen_done = seen_done | done;
        end
        check("mrst_no_done", 32'(seen_done), 32'd0);
        check("mrst_m600", mem[600], 32'hA000_0000);
        check("mrst_m601", mem[601], 32'hA000_0001);
        check("mrst_m602", mem[602], 32'hA000_025A);

        run(1'b1, 32'd0, 32'd700, 11'd2, 32'h0000_1234, 0, lat, err_v, wpat, wen_any);
        check("post_lat", 32'(lat), 32'd3);
        check("post_m700", mem[700], 32'h0000_1234);
        check("post_m701", mem[701], 32'h0000_1234);
        check("post_m702", mem[702], 32'hA000_02BE);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
